// File: rtl/cpu_pkg.sv
// Shared definitions for the Top8 fetch front end.
// FSM encodings and fetch-width constants.
package cpu_pkg;

    localparam int DEFAULT_ADDR_W = 64;
    localparam int INSTR_BYTES    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HALT  = 3'd3
    } fsm_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter flop with load/hold/advance mux and +4 adder.
module pc_register
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    assign pc_plus4_o = pc_q + ADDR_W'(INSTR_BYTES);
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (adv_i) begin
            pc_d = pc_plus4_o;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC controller: steps fetch, applies stalls/redirects, drains the
// pipeline after the instruction budget or a halt request.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                MAX_INSTR    = 15,
    parameter int                DRAIN_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_en,
    output logic              if_id_write,
    output logic              flush_if_id,
    output logic [7:0]        instr_count,
    output logic              done,
    output logic [2:0]        state
);

    fsm_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d, cnt_inc;
    logic [7:0]        drain_q, drain_d;
    logic              pc_load, pc_adv;
    logic [ADDR_W-1:0] tgt_aligned;

    assign tgt_aligned = branch_target & ~ADDR_W'(3);
    assign cnt_inc     = cnt_q + 8'd1;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (pc_load),
        .adv_i      (pc_adv),
        .target_i   (tgt_aligned),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        pc_load     = 1'b0;
        pc_adv      = 1'b0;
        fetch_en    = 1'b0;
        if_id_write = 1'b0;
        flush_if_id = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                fetch_en    = !stall || branch_taken;
                if_id_write = !stall || branch_taken;
                flush_if_id = branch_taken;
                // A halt stops sequential advance but a redirect still lands
                if (branch_taken) begin
                    pc_load = 1'b1;
                end else if (!stall && !halt_req) begin
                    pc_adv = 1'b1;
                    cnt_d  = cnt_inc;
                end
                if (halt_req || (pc_adv && cnt_inc == 8'(MAX_INSTR))) begin
                    state_d = ST_DRAIN;
                    drain_d = 8'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if_id_write = 1'b1;
                flush_if_id = branch_taken;
                if (drain_q == 8'd0) begin
                    state_d = ST_HALT;
                end else begin
                    drain_d = drain_q - 8'd1;
                end
            end
            ST_HALT: begin
                done = 1'b1;
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            drain_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    assign instr_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic        halt_req = 1'b0;
    logic [63:0] pc, pc_plus4;
    logic        fetch_en, if_id_write, flush_if_id, done;
    logic [7:0]  instr_count;
    logic [2:0]  state;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic        st, sl, br;
        logic [63:0] tgt;
        logic        hr;
        logic [63:0] epc;
        logic [2:0]  est;
        logic        efe, eif, efl;
        logic [7:0]  ecnt;
        logic        edone;
    } vec_t;

    vec_t vq[$];

    fetch_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_en      (fetch_en),
        .if_id_write   (if_id_write),
        .flush_if_id   (flush_if_id),
        .instr_count   (instr_count),
        .done          (done),
        .state         (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic st, input logic sl, input logic br,
                       input logic [63:0] tgt, input logic hr,
                       input logic [63:0] epc, input logic [2:0] est,
                       input logic efe, input logic eif, input logic efl,
                       input logic [7:0] ecnt, input logic edone);
        vec_t v;
        v.st = st; v.sl = sl; v.br = br; v.tgt = tgt; v.hr = hr;
        v.epc = epc; v.est = est; v.efe = efe; v.eif = eif;
        v.efl = efl; v.ecnt = ecnt; v.edone = edone;
        vq.push_back(v);
    endtask

    task automatic run_plain(input logic [63:0] p, input logic [7:0] c);
        add(0, 0, 0, 64'h0, 0, p, 3'd1, 1, 1, 0, c, 0);
    endtask

    task automatic idle_start();
        add(0, 0, 0, 64'h0, 0, 64'h0, 3'd0, 0, 0, 0, 8'd0, 0);
        add(1, 0, 0, 64'h0, 0, 64'h0, 3'd0, 0, 0, 0, 8'd0, 0);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clock);
            start = vq[i].st; stall = vq[i].sl;
            branch_taken = vq[i].br; branch_target = vq[i].tgt;
            halt_req = vq[i].hr;
            #1;
            check($sformatf("%s[%0d].pc", tag, i), pc, vq[i].epc);
            check($sformatf("%s[%0d].pc4", tag, i), pc_plus4,
                  vq[i].epc + 64'd4);
            check($sformatf("%s[%0d].state", tag, i), state, vq[i].est);
            check($sformatf("%s[%0d].fetch_en", tag, i), fetch_en, vq[i].efe);
            check($sformatf("%s[%0d].if_id_write", tag, i), if_id_write,
                  vq[i].eif);
            check($sformatf("%s[%0d].flush", tag, i), flush_if_id, vq[i].efl);
            check($sformatf("%s[%0d].count", tag, i), instr_count, vq[i].ecnt);
            check($sformatf("%s[%0d].done", tag, i), done, vq[i].edone);
        end
        vq.delete();
    endtask

    // Asserts reset between clock edges and checks outputs before any edge.
    task automatic async_reset(input string tag);
        #2;
        start = 0; stall = 0; branch_taken = 0;
        branch_target = '0; halt_req = 0;
        reset_n = 1'b0;
        #1;
        check({tag, ".rst_state"}, state, 64'd0);
        check({tag, ".rst_pc"}, pc, 64'd0);
        check({tag, ".rst_count"}, instr_count, 64'd0);
        check({tag, ".rst_done"}, done, 64'd0);
        check({tag, ".rst_fetch"}, fetch_en, 64'd0);
        check({tag, ".rst_ifid"}, if_id_write, 64'd0);
        check({tag, ".rst_flush"}, flush_if_id, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        async_reset("init");

        // Full budget run, drain, halt, restart from held pc
        idle_start();
        for (int i = 0; i < 15; i++) run_plain(64'(4 * i), 8'(i));
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 64'h0, 0, 64'd60, 3'd2, 0, 1, 0, 8'd15, 0);
        add(0, 1, 0, 64'h0, 0, 64'd60, 3'd3, 0, 0, 0, 8'd15, 1);
        add(1, 0, 0, 64'h0, 0, 64'd60, 3'd3, 0, 0, 0, 8'd15, 1);
        run_plain(64'd60, 8'd0);
        run_plain(64'd64, 8'd1);
        run_vecs("budget");

        // Stall, branch+stall, halt+branch, drain ignores start/stall
        async_reset("hz");
        idle_start();
        run_plain(64'd0, 8'd0);
        run_plain(64'd4, 8'd1);
        add(0, 1, 0, 64'h0, 0, 64'd8, 3'd1, 0, 0, 0, 8'd2, 0);
        add(0, 1, 0, 64'h0, 0, 64'd8, 3'd1, 0, 0, 0, 8'd2, 0);
        run_plain(64'd8, 8'd2);
        run_plain(64'd12, 8'd3);
        run_plain(64'd16, 8'd4);
        add(0, 1, 1, 64'h42, 0, 64'd20, 3'd1, 1, 1, 1, 8'd5, 0);
        run_plain(64'h40, 8'd5);
        run_plain(64'h44, 8'd6);
        add(0, 0, 1, 64'h103, 1, 64'h48, 3'd1, 1, 1, 1, 8'd7, 0);
        add(0, 0, 1, 64'h0, 0, 64'h100, 3'd2, 0, 1, 1, 8'd7, 0);
        add(1, 1, 0, 64'h0, 0, 64'h100, 3'd2, 0, 1, 0, 8'd7, 0);
        add(0, 0, 0, 64'h0, 0, 64'h100, 3'd2, 0, 1, 0, 8'd7, 0);
        add(0, 0, 0, 64'h0, 0, 64'h100, 3'd2, 0, 1, 0, 8'd7, 0);
        add(0, 0, 0, 64'h0, 0, 64'h100, 3'd3, 0, 0, 0, 8'd7, 1);
        run_vecs("hazard");

        // Early halt at pc=16, restart, then reset mid-drain
        async_reset("hlt");
        idle_start();
        for (int i = 0; i < 4; i++) run_plain(64'(4 * i), 8'(i));
        add(0, 0, 0, 64'h0, 1, 64'd16, 3'd1, 1, 1, 0, 8'd4, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 64'h0, 0, 64'd16, 3'd2, 0, 1, 0, 8'd4, 0);
        add(1, 0, 0, 64'h0, 0, 64'd16, 3'd3, 0, 0, 0, 8'd4, 1);
        add(0, 0, 0, 64'h0, 1, 64'd16, 3'd1, 1, 1, 0, 8'd0, 0);
        add(0, 0, 0, 64'h0, 0, 64'd16, 3'd2, 0, 1, 0, 8'd0, 0);
        run_vecs("halt");
        async_reset("middrain");

        // Address wrap via redirect to the top word
        idle_start();
        add(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0, 3'd1, 1, 1, 1,
            8'd0, 0);
        run_plain(64'hFFFF_FFFF_FFFF_FFFC, 8'd0);
        run_plain(64'd0, 8'd1);
        run_plain(64'd4, 8'd2);
        run_vecs("wrap");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter controller for the five-stage pipelined ARM datapath (Top8). It replaces manual PC stepping by a bench: it owns the PC register and advances it by 4 each cycle. It also applies hazard stalls and branch redirects with IF/ID flush, and stops fetch after a programmed instruction budget. Once fetch stops it drains the pipeline and then reports done.

Parameters:
ADDR_W, 64, PC/address width
RESET_PC, 0, PC value after reset
MAX_INSTR, 15, sequential fetches before auto-drain (1..255)
DRAIN_CYCLES, 4, cycles to let in-flight instructions retire (pipeline depth - 1)

Ports:
clock  in  1  single system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  level; begin/resume fetching
stall  in  1  load-use hazard from hazard unit; hold PC and IF/ID
branch_taken  in  1  branch resolved taken (from MEM stage)
branch_target  in  ADDR_W  redirect address
halt_req  in  1  force early drain
pc  out  ADDR_W  registered fetch address to instruction memory
pc_plus4  out  ADDR_W  pc + 4, combinational (feeds IF/ID, AdderOut equivalent)
fetch_en  out  1  instruction fetch valid this cycle
if_id_write  out  1  IF/ID register write enable
flush_if_id  out  1  squash IF/ID (and ID/EX) contents
instr_count  out  8  sequential fetches completed
done  out  1  HALT state indicator
state  out  3  encoded FSM state for debug

Behaviour:
- Asynchronous reset (reset_n=0) applies immediately regardless of clock: state=IDLE, pc=RESET_PC, instr_count=0, drain counter=0. Outputs then read done=0, fetch_en=0, flush_if_id=0, if_id_write=0.
- FSM states: IDLE=0, RUN=1, DRAIN=2, HALT=3. All other encodings recover to IDLE.
- IDLE: pc held. start=1 -> RUN at next edge.
- RUN outputs, all combinational from state and inputs:
  - fetch_en = !stall || branch_taken
  - if_id_write = !stall || branch_taken
  - flush_if_id = branch_taken
- RUN updates at each edge, in priority order:
  1. branch_taken: pc <= {branch_target[ADDR_W-1:2],2'b00}. Count unchanged, because the wrong-path fetch is squashed. Branch wins over a simultaneous stall.
  2. stall: pc and count held.
  3. Otherwise: pc <= pc+4 (wraps modulo 2^ADDR_W) and count <= count+1.
- RUN -> DRAIN when either:
  - the incremented count equals MAX_INSTR at that edge, or
  - halt_req=1. If branch_taken is also set in that cycle, the redirect is still applied to pc first.
- On entering DRAIN, the drain counter loads DRAIN_CYCLES-1.
- DRAIN: fetch_en=0, if_id_write=1, pc frozen. flush_if_id = branch_taken. Counter decrements each cycle; at 0 -> HALT.
- HALT: done=1, fetch_en=0, if_id_write=0, flush_if_id=0. start=1 -> RUN with instr_count cleared and pc unchanged.
- No fetch is issued in IDLE, DRAIN or HALT. start is ignored in RUN and DRAIN. stall is ignored outside RUN.
- Reset mid-RUN or mid-DRAIN abandons all state. There is no partial drain.

Decomposition:
- Shared package cpu_pkg:
  - FSM state encodings
  - INSTR_BYTES=4
  - default ADDR_W=64
- One sub-module, pc_register: ADDR_W flop with async active-low reset to RESET_PC, plus a load/hold mux and a +4 adder. The FSM and counters live in fetch_sequencer.

Test Plan:
1. Reset, then start pulse, no hazards -> pc steps 0,4,8,...,56. After the 15th fetch: DRAIN for 4 cycles, done=1, instr_count=15, pc=60.
2. stall=1 for 2 cycles at pc=8 -> pc holds 8 for those cycles, fetch_en=0, if_id_write=0. Resumes at 12, instr_count unaffected by stalled cycles.
3. branch_taken=1 with target 0x42 at pc=20, stall=1 simultaneously -> flush_if_id=1 and fetch_en=1 that cycle. Next pc=0x40, count not incremented.
4. halt_req=1 at pc=16 -> next state DRAIN, fetch_en=0, pc frozen at 16. done asserts 4 cycles later.
5. pc=0xFFFFFFFFFFFFFFFC in RUN -> next pc=0 (wrap), count increments.
6. reset_n=0 asynchronously mid-DRAIN (between edges) -> state=IDLE, pc=0, done=0, instr_count=0 immediately. start in HALT restarts RUN from the held pc with count=0.
